// File: rtl/data_v_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_v_pkg : shared constants for the data_v multicycle datapath     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package data_v_pkg;

  localparam int DATAV_WIDTH   = 8;
  localparam int DATAV_REGBITS = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_ALU_B  = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/data_v_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_v_if : controller-facing selects, memory bus and observation    |
// | taps of the data_v datapath.  Rev 1.0                                |
// +----------------------------------------------------------------------+
interface data_v_if #(
  parameter int WIDTH = 8
) ();

  logic [WIDTH-1:0] memdata;
  logic             alusrca;
  logic             memtoreg;
  logic             regdst;
  logic             iord;
  logic             pcen;
  logic             regwrite;
  logic [1:0]       pcsrc;
  logic [1:0]       alusrcb;
  logic [3:0]       irwrite;
  logic [2:0]       alucontrol;

  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [WIDTH-1:0] alucheck;
  logic [WIDTH-1:0] pcvalue;
  logic [WIDTH-1:0] nextpcvalue;
  logic [WIDTH-1:0] read1;
  logic [WIDTH-1:0] read2;
  logic [WIDTH-1:0] RgDst;
  logic             zero;
  logic [31:0]      instr;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;

  modport master (
    output memdata, alusrca, memtoreg, regdst, iord, pcen, regwrite,
           pcsrc, alusrcb, irwrite, alucontrol,
    input  src1, src2, alucheck, pcvalue, nextpcvalue, read1, read2,
           RgDst, zero, instr, adr, writedata
  );

  modport slave (
    input  memdata, alusrca, memtoreg, regdst, iord, pcen, regwrite,
           pcsrc, alusrcb, irwrite, alucontrol,
    output src1, src2, alucheck, pcvalue, nextpcvalue, read1, read2,
           RgDst, zero, instr, adr, writedata
  );

endinterface
`default_nettype wire

// File: rtl/data_v_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_v_regfile : 2-read / 1-write register file, r0 reads zero,      |
// | r1/r2 preloaded from a1/b1 during reset.  Rev 1.0                    |
// +----------------------------------------------------------------------+
module data_v_regfile
  import data_v_pkg::*;
#(
  parameter int WIDTH   = DATAV_WIDTH,
  parameter int REGBITS = DATAV_REGBITS
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic [WIDTH-1:0]   a1,
  input  wire logic [WIDTH-1:0]   b1,
  input  wire logic [REGBITS-1:0] ra1,
  input  wire logic [REGBITS-1:0] ra2,
  input  wire logic               we,
  input  wire logic [REGBITS-1:0] wa,
  input  wire logic [WIDTH-1:0]   wd,
  output logic      [WIDTH-1:0]   rd1,
  output logic      [WIDTH-1:0]   rd2
);

  localparam int NREGS = 2**REGBITS;

  logic [WIDTH-1:0] rf [NREGS];

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == 0) begin : g_zero
      assign rf[i] = '0;
    end else begin : g_live
      logic [WIDTH-1:0] reg_d;
      logic [WIDTH-1:0] reg_q;
      logic [WIDTH-1:0] init_val;

      assign init_val = (i == 1) ? a1 : (i == 2) ? b1 : '0;

      always_comb begin
        reg_d = reg_q;
        if (we && (wa == REGBITS'(i))) reg_d = wd;
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) reg_q <= init_val;
        else       reg_q <= reg_d;
      end

      assign rf[i] = reg_q;
    end
  end

  // Reads see the registered contents, so a same-cycle write shows up next cycle.
  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

endmodule
`default_nettype wire

// File: rtl/data_v.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_v : 8-bit multicycle MIPS-subset datapath (PC, IR, MDR, A/B,    |
// | ALUOut, regfile, ALU). Macro DATAV_JUMP_EN enables the jump target.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_v
  import data_v_pkg::*;
#(
  parameter int WIDTH   = DATAV_WIDTH,
  parameter int REGBITS = DATAV_REGBITS
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] a1,
  input  wire logic [WIDTH-1:0] b1,
  data_v_if.slave               bus
);

  logic [WIDTH-1:0]   pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [WIDTH-1:0]   mdr_q, mdr_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   aluout_q, aluout_d;

  logic [WIDTH-1:0]   src1, src2, alucheck, nextpc, jump_target;
  logic [WIDTH-1:0]   read1, read2, wd;
  logic [REGBITS-1:0] rs, rt, rd, wa;

  assign rs = instr_q[21 +: REGBITS];
  assign rt = instr_q[16 +: REGBITS];
  assign rd = instr_q[11 +: REGBITS];
  assign wa = bus.regdst   ? rd    : rt;
  assign wd = bus.memtoreg ? mdr_q : aluout_q;

  data_v_regfile #(
    .WIDTH   (WIDTH),
    .REGBITS (REGBITS)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .a1    (a1),
    .b1    (b1),
    .ra1   (rs),
    .ra2   (rt),
    .we    (bus.regwrite),
    .wa    (wa),
    .wd    (wd),
    .rd1   (read1),
    .rd2   (read2)
  );

`ifdef DATAV_JUMP_EN
  assign jump_target = {instr_q[WIDTH-3:0], 2'b00};
`else
  assign jump_target = alucheck;
`endif

  always_comb begin
    src1 = bus.alusrca ? a_q : pc_q;

    case (bus.alusrcb)
      SRCB_B:     src2 = b_q;
      SRCB_ONE:   src2 = WIDTH'(1);
      SRCB_IMM:   src2 = instr_q[WIDTH-1:0];
      default:    src2 = {instr_q[WIDTH-3:0], 2'b00};
    endcase

    case (bus.alucontrol)
      ALU_ADD: alucheck = src1 + src2;
      ALU_AND: alucheck = src1 & src2;
      ALU_OR:  alucheck = src1 | src2;
      ALU_SUB: alucheck = src1 - src2;
      ALU_SLT: alucheck = {{(WIDTH-1){1'b0}}, (src1 < src2)};
      default: alucheck = '0;
    endcase

    case (bus.pcsrc)
      PCSRC_ALUOUT: nextpc = aluout_q;
      PCSRC_JUMP:   nextpc = jump_target;
      default:      nextpc = alucheck;
    endcase
  end

  always_comb begin
    pc_d     = bus.pcen ? nextpc : pc_q;
    instr_d  = instr_q;
    // Each enabled IR byte lane captures the same memory byte.
    for (int i = 0; i < 4; i++) begin
      if (bus.irwrite[i]) instr_d[8*i +: 8] = bus.memdata[7:0];
    end
    mdr_d    = bus.memdata;
    a_d      = read1;
    b_d      = read2;
    aluout_d = alucheck;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      instr_q  <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  assign bus.src1        = src1;
  assign bus.src2        = src2;
  assign bus.alucheck    = alucheck;
  assign bus.pcvalue     = pc_q;
  assign bus.nextpcvalue = nextpc;
  assign bus.read1       = read1;
  assign bus.read2       = read2;
  assign bus.RgDst       = WIDTH'(wa);
  assign bus.zero        = (alucheck == '0);
  assign bus.instr       = instr_q;
  assign bus.adr         = bus.iord ? aluout_q : pc_q;
  assign bus.writedata   = b_q;

endmodule
`default_nettype wire

// File: tb/tb_data_v.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_v : directed stimulus with a queued expected-value monitor   |
// | for data_v.  Rev 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_data_v;

  localparam int S_PC = 0, S_NPC = 1, S_INSTR = 2, S_ADR = 3, S_R1 = 4,
                 S_R2 = 5, S_RGDST = 6, S_SRC1 = 7, S_SRC2 = 8, S_ALU = 9,
                 S_ZERO = 10, S_WDATA = 11;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_item_t;

  logic       clk;
  logic       reset;
  logic [7:0] a1, b1;
  int         checks;
  int         errors;
  sb_item_t   sb[$];

  data_v_if #(.WIDTH(8)) bus ();

  data_v #(.WIDTH(8), .REGBITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .a1    (a1),
    .b1    (b1),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] actual_of(input int sel);
    case (sel)
      S_PC:    return {24'h0, bus.pcvalue};
      S_NPC:   return {24'h0, bus.nextpcvalue};
      S_INSTR: return bus.instr;
      S_ADR:   return {24'h0, bus.adr};
      S_R1:    return {24'h0, bus.read1};
      S_R2:    return {24'h0, bus.read2};
      S_RGDST: return {24'h0, bus.RgDst};
      S_SRC1:  return {24'h0, bus.src1};
      S_SRC2:  return {24'h0, bus.src2};
      S_ALU:   return {24'h0, bus.alucheck};
      S_ZERO:  return {31'h0, bus.zero};
      default: return {24'h0, bus.writedata};
    endcase
  endfunction

  // Monitor: drains every queued expectation at the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      sb_item_t it;
      logic [31:0] act;
      it  = sb.pop_front();
      act = actual_of(it.sel);
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s actual %h required %h at %0t", it.name, act, it.exp, $time);
      end
    end
  end

  task automatic expect_val(input int sel, input logic [31:0] v, input string nm);
    sb_item_t it;
    it.sel  = sel;
    it.exp  = v;
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.memdata    = 8'h00;
    bus.alusrca    = 1'b0;
    bus.memtoreg   = 1'b0;
    bus.regdst     = 1'b0;
    bus.iord       = 1'b0;
    bus.pcen       = 1'b0;
    bus.regwrite   = 1'b0;
    bus.pcsrc      = 2'b00;
    bus.alusrcb    = 2'b00;
    bus.irwrite    = 4'b0000;
    bus.alucontrol = 3'b000;
  endtask

  task automatic load_byte(input logic [3:0] en, input logic [7:0] d);
    bus.irwrite = en;
    bus.memdata = d;
  endtask

  logic [7:0] jump_pc;

  initial begin
    checks = 0;
    errors = 0;
`ifdef DATAV_JUMP_EN
    jump_pc = 8'h14;
`else
    jump_pc = 8'h48;
`endif
    reset = 1'b1;
    a1    = 8'h33;
    b1    = 8'h24;
    clr();
    step();
    expect_val(S_PC, 32'h0, "reset_pc");
    expect_val(S_INSTR, 32'h0, "reset_instr");
    expect_val(S_ADR, 32'h0, "reset_adr");
    step();
    reset = 1'b0;

    // Fetch four bytes of 00221820h
    clr(); load_byte(4'b0001, 8'h20); step();
    clr(); load_byte(4'b0010, 8'h18); step();
    clr(); load_byte(4'b0100, 8'h22); step();
    clr(); load_byte(4'b1000, 8'h00); step();

    clr();
    expect_val(S_INSTR, 32'h0022_1820, "fetch_instr");
    expect_val(S_R1, 32'h33, "preload_r1");
    expect_val(S_R2, 32'h24, "preload_r2");
    expect_val(S_RGDST, 32'h2, "rgdst_rt");
    step();

    // PC increment over two edges
    clr(); bus.regdst = 1'b1; bus.alusrcb = 2'b01; bus.pcen = 1'b1;
    expect_val(S_RGDST, 32'h3, "rgdst_rd");
    expect_val(S_SRC1, 32'h0, "inc_src1");
    expect_val(S_SRC2, 32'h1, "inc_src2");
    expect_val(S_NPC, 32'h1, "inc_npc0");
    expect_val(S_PC, 32'h0, "inc_pc0");
    step();
    clr(); bus.alusrcb = 2'b01; bus.pcen = 1'b1;
    expect_val(S_PC, 32'h1, "inc_pc1");
    expect_val(S_NPC, 32'h2, "inc_npc1");
    step();

    // R-type ADD then write r3
    clr(); bus.alusrca = 1'b1;
    expect_val(S_PC, 32'h2, "inc_pc2");
    expect_val(S_SRC1, 32'h33, "add_src1");
    expect_val(S_SRC2, 32'h24, "add_src2");
    expect_val(S_ALU, 32'h57, "add_result");
    expect_val(S_ZERO, 32'h0, "add_zero");
    step();
    clr(); bus.regdst = 1'b1; bus.regwrite = 1'b1; bus.iord = 1'b1;
    expect_val(S_ADR, 32'h57, "adr_aluout");
    expect_val(S_WDATA, 32'h24, "writedata_b");
    step();

    // Read r3 back via rt, then point rd at r0
    clr(); load_byte(4'b0100, 8'h23);
    expect_val(S_R2, 32'h24, "r2_before_reload");
    step();
    clr(); load_byte(4'b0010, 8'h00);
    expect_val(S_INSTR, 32'h0023_1820, "instr_rt3");
    expect_val(S_R2, 32'h57, "r3_written");
    expect_val(S_ALU, 32'h26, "pc_plus_b");
    step();
    clr(); bus.regdst = 1'b1; bus.regwrite = 1'b1;
    expect_val(S_RGDST, 32'h0, "rgdst_r0");
    step();
    clr(); load_byte(4'b0100, 8'h03); step();
    clr(); load_byte(4'b0100, 8'h22);
    expect_val(S_R1, 32'h0, "r0_reads_zero");
    expect_val(S_R2, 32'h57, "r3_still");
    step();
    clr();
    expect_val(S_R1, 32'h33, "r1_again");
    step();

    // SUB / SLT / pcsrc=01
    clr(); bus.alusrca = 1'b1; bus.alucontrol = 3'b110;
    expect_val(S_ALU, 32'h0F, "sub_result");
    expect_val(S_ZERO, 32'h0, "sub_zero");
    step();
    clr(); bus.alusrca = 1'b1; bus.alucontrol = 3'b111;
    bus.pcsrc = 2'b01; bus.pcen = 1'b1;
    expect_val(S_ALU, 32'h00, "slt_result");
    expect_val(S_ZERO, 32'h1, "slt_zero");
    expect_val(S_NPC, 32'h0F, "npc_aluout");
    step();
    clr(); load_byte(4'b0100, 8'h42);
    expect_val(S_PC, 32'h0F, "pc_from_aluout");
    step();
    clr();
    expect_val(S_R1, 32'h24, "rs2_read");
    expect_val(S_R2, 32'h24, "rt2_read");
    step();
    clr(); bus.alusrca = 1'b1; bus.alucontrol = 3'b110;
    expect_val(S_ALU, 32'h00, "sub_equal");
    expect_val(S_ZERO, 32'h1, "sub_equal_zero");
    step();
    clr(); bus.alusrca = 1'b1; bus.alucontrol = 3'b010;
    expect_val(S_ALU, 32'h24, "or_result");
    step();
    clr(); bus.alusrca = 1'b1; bus.alucontrol = 3'b011;
    expect_val(S_ALU, 32'h00, "undef_op");
    step();

    // Immediates, wrap and jump
    clr(); bus.alusrca = 1'b1; bus.alusrcb = 2'b10; load_byte(4'b0001, 8'hF0);
    expect_val(S_SRC2, 32'h20, "imm_src2");
    expect_val(S_ALU, 32'h44, "imm_add");
    step();
    clr(); bus.alusrca = 1'b1; bus.alusrcb = 2'b10; load_byte(4'b0001, 8'h05);
    expect_val(S_ALU, 32'h14, "add_wrap");
    step();
    clr(); bus.alusrca = 1'b1; bus.alusrcb = 2'b11;
    expect_val(S_SRC2, 32'h14, "immsh_src2");
    expect_val(S_ALU, 32'h38, "immsh_add");
    step();
    clr(); bus.alusrca = 1'b1; bus.pcsrc = 2'b10; bus.pcen = 1'b1;
    expect_val(S_ALU, 32'h48, "jump_cycle_alu");
    expect_val(S_NPC, {24'h0, jump_pc}, "jump_npc");
    step();
    clr(); bus.alusrcb = 2'b01; bus.pcsrc = 2'b11;
    expect_val(S_PC, {24'h0, jump_pc}, "jump_pc");
    expect_val(S_NPC, {24'h0, jump_pc + 8'h01}, "pcsrc11_npc");
    step();

    // Asynchronous reset between edges, with new preload values
    clr(); a1 = 8'h5A; b1 = 8'hA5;
    reset = 1'b1;
    expect_val(S_PC, 32'h0, "midreset_pc");
    expect_val(S_INSTR, 32'h0, "midreset_instr");
    expect_val(S_ADR, 32'h0, "midreset_adr");
    expect_val(S_WDATA, 32'h0, "midreset_b");
    expect_val(S_NPC, 32'h0, "midreset_npc");
    step();
    reset = 1'b0;
    clr(); load_byte(4'b0100, 8'h23); step();
    clr(); load_byte(4'b0100, 8'h22);
    expect_val(S_R1, 32'h5A, "reload_r1");
    expect_val(S_R2, 32'h00, "r3_cleared");
    step();
    clr();
    expect_val(S_R2, 32'hA5, "reload_r2");
    step();

    for (int n = 0; n < 10 && sb.size() > 0; n++) step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
